// File: rtl/fetch_buffer.sv
// Instruction fetch buffer: captures (PC, instruction) pairs from the PC/ROM stage
// into a small circular FIFO and hands them to decode over a valid/ready handshake.
module fetch_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned SKID  = 2,
    parameter int unsigned AW    = 32,
    parameter int unsigned DW    = 32
) (
    input  logic                     clk_i_FB,
    input  logic                     reset_i_FB,
    input  logic [AW-1:0]            pc_addr_i_FB,
    input  logic                     chip_enable_i_FB,
    input  logic [DW-1:0]            inst_i_FB,
    input  logic                     flush_i_FB,
    input  logic                     ready_i_FB,
    output logic [AW-1:0]            pc_o_FB,
    output logic [DW-1:0]            inst_o_FB,
    output logic                     valid_o_FB,
    output logic                     pc_hold_o_FB,
    output logic [$clog2(DEPTH):0]   count_o_FB,
    output logic                     overflow_o_FB
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_LEVEL = (PW+1)'(DEPTH);
    localparam logic [PW:0] HOLD_LEVEL = (PW+1)'(DEPTH - SKID);

    logic [AW-1:0] pc_mem   [DEPTH];
    logic [DW-1:0] inst_mem [DEPTH];
    logic [PW-1:0] wp;
    logic [PW-1:0] rp;
    logic [PW:0]   count;
    logic          overflow;

    logic full;
    logic pop;
    logic push;

    always_comb begin
        full = (count == FULL_LEVEL);
        pop  = (count != '0) & ready_i_FB & ~flush_i_FB;
        // A full buffer still accepts a fetch when the head leaves in the same cycle.
        push = chip_enable_i_FB & ~flush_i_FB & (~full | pop);
    end

    always_ff @(posedge clk_i_FB) begin
        if (reset_i_FB) begin
            wp       <= '0;
            rp       <= '0;
            count    <= '0;
            overflow <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pc_mem[i]   <= '0;
                inst_mem[i] <= '0;
            end
        end else if (flush_i_FB) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push) begin
                pc_mem[wp]   <= pc_addr_i_FB;
                inst_mem[wp] <= inst_i_FB;
                wp           <= wp + PW'(1);
            end
            if (pop) begin
                rp <= rp + PW'(1);
            end
            if (push && !pop) begin
                count <= count + (PW+1)'(1);
            end else if (pop && !push) begin
                count <= count - (PW+1)'(1);
            end
            if (chip_enable_i_FB && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Hold is decoded from the registered count only, so it has no input-to-output path.
    assign pc_o_FB       = pc_mem[rp];
    assign inst_o_FB     = inst_mem[rp];
    assign valid_o_FB    = (count != '0);
    assign pc_hold_o_FB  = (count >= HOLD_LEVEL);
    assign count_o_FB    = count;
    assign overflow_o_FB = overflow;

endmodule

// File: tb/tb_fetch_buffer.sv
// Randomized scoreboard bench for fetch_buffer against a queue-based reference model.
module tb_fetch_buffer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned SKID  = 2;
    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;

    typedef struct {
        logic [AW-1:0] pc;
        logic [DW-1:0] inst;
    } entry_t;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [AW-1:0]         pc;
    logic                  ce;
    logic [DW-1:0]         inst;
    logic                  flush;
    logic                  ready;
    logic [AW-1:0]         pc_out;
    logic [DW-1:0]         inst_out;
    logic                  valid;
    logic                  hold;
    logic [$clog2(DEPTH):0] count;
    logic                  overflow;

    fetch_buffer #(
        .DEPTH(DEPTH),
        .SKID (SKID),
        .AW   (AW),
        .DW   (DW)
    ) dut (
        .clk_i_FB        (clk),
        .reset_i_FB      (reset),
        .pc_addr_i_FB    (pc),
        .chip_enable_i_FB(ce),
        .inst_i_FB       (inst),
        .flush_i_FB      (flush),
        .ready_i_FB      (ready),
        .pc_o_FB         (pc_out),
        .inst_o_FB       (inst_out),
        .valid_o_FB      (valid),
        .pc_hold_o_FB    (hold),
        .count_o_FB      (count),
        .overflow_o_FB   (overflow)
    );

    always #5 clk = ~clk;

    int     n_cmp = 0;
    int     n_bad = 0;

    // Reference model: occupancy, sticky overflow, and the queue of expected deliveries.
    entry_t sb[$];
    int     m_cnt = 0;
    logic   m_ovf = 1'b0;
    logic   zero_head = 1'b0;
    logic   started = 1'b0;
    logic   m_pop;
    logic   m_acc;

    assign m_pop = (m_cnt != 0) && ready && !flush;
    assign m_acc = ce && !flush && ((m_cnt < int'(DEPTH)) || m_pop);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            m_cnt     <= 0;
            m_ovf     <= 1'b0;
            sb.delete();
            zero_head <= 1'b1;
            started   <= 1'b1;
        end else if (started) begin
            if (flush) begin
                m_cnt <= 0;
                sb.delete();
            end else begin
                if (m_acc) begin
                    sb.push_back('{pc: pc, inst: inst});
                    zero_head <= 1'b0;
                end else if (ce) begin
                    m_ovf <= 1'b1;
                end
                m_cnt <= m_cnt + (m_acc ? 1 : 0) - (m_pop ? 1 : 0);
            end
        end
    end

    // Monitor: outputs are sampled mid-cycle; a handshake retires the head expectation.
    always @(negedge clk) begin
        if (started) begin
            chk("count", 64'(count), 64'(m_cnt));
            chk("valid", 64'(valid), 64'(m_cnt != 0));
            chk("hold", 64'(hold), 64'(m_cnt >= int'(DEPTH - SKID)));
            chk("overflow", 64'(overflow), 64'(m_ovf));
            if (zero_head && m_cnt == 0) begin
                chk("reset_pc", 64'(pc_out), 64'(0));
                chk("reset_inst", 64'(inst_out), 64'(0));
            end
            if (valid) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL spurious_valid: got pc 0x%0h, expected no entry at %0t", pc_out, $time);
                end else begin
                    chk("head_pc", 64'(pc_out), 64'(sb[0].pc));
                    chk("head_inst", 64'(inst_out), 64'(sb[0].inst));
                    if (ready && !flush && !reset) begin
                        void'(sb.pop_front());
                    end
                end
            end
        end
    end

    task automatic step(input logic c, input logic [AW-1:0] p, input logic [DW-1:0] i,
                        input logic r, input logic f);
        ce    = c;
        pc    = p;
        inst  = i;
        ready = r;
        flush = f;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        ce    = 1'b0;
        flush = 1'b0;
        ready = 1'b0;
        pc    = '0;
        inst  = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Streaming with decode always ready
        for (int i = 0; i < 8; i++) step(1'b1, AW'(i), 32'h1000_0000 + DW'(i), 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) step(1'b0, '0, '0, 1'b1, 1'b0);

        // Stall fill: four accepted, fifth dropped
        for (int i = 0; i < 5; i++) step(1'b1, AW'(i), 32'h1000_0000 + DW'(i), 1'b0, 1'b0);
        // Release
        for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b1, 1'b0);

        // Full with simultaneous push and pop
        for (int i = 0; i < 4; i++) step(1'b1, AW'(32'h10 + i), 32'h2000_0000 + DW'(i), 1'b0, 1'b0);
        step(1'b1, AW'(9), 32'h3000_0009, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, '0, '0, 1'b1, 1'b0);

        // Flush with an incoming fetch and a ready decode
        for (int i = 5; i < 8; i++) step(1'b1, AW'(i), 32'h1000_0000 + DW'(i), 1'b0, 1'b0);
        step(1'b1, AW'(8), 32'h1000_0008, 1'b1, 1'b1);
        step(1'b1, AW'(32'h20), 32'h1000_0020, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) step(1'b0, '0, '0, 1'b1, 1'b0);

        // Random traffic with occasional flushes; pointers wrap many times
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 3) != 0, $urandom, $urandom,
                 1'($urandom_range(0, 1)), $urandom_range(0, 19) == 0);
        end

        // Reset mid-stream
        for (int i = 0; i < 3; i++) step(1'b1, AW'(32'h40 + i), 32'h4000_0000 + DW'(i), 1'b0, 1'b0);
        reset = 1'b1;
        step(1'b1, AW'(32'h50), 32'h5000_0000, 1'b1, 1'b0);
        reset = 1'b0;
        step(1'b0, '0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step($urandom_range(0, 1) != 0, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);
        end
        for (int i = 0; i < 6; i++) step(1'b0, '0, '0, 1'b1, 1'b0);

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_buffer.md
# fetch_buffer

Instruction fetch buffer sitting directly downstream of the PC generator and the instruction ROM. Each cycle the PC presents a word address with chip enable high, the ROM returns the matching instruction combinationally, and this block captures the (PC, instruction) pair into a small FIFO. It then hands pairs to the decode stage over a valid/ready handshake. It absorbs decode stalls, raises a hold request toward the PC before it fills, and discards everything on a flush.

## Interface
- DEPTH, 4, number of entries; power of two, >= 2
- SKID, 2, free entries reserved for in-flight fetches; 1 <= SKID < DEPTH
- AW, 32, PC width (word address)
- DW, 32, instruction width
- clk_i_FB  in  1  clock; all state updates on rising edge
- reset_i_FB  in  1  reset, synchronous, active-high (`RstEnable` = 1)
- pc_addr_i_FB  in  AW  fetch address from PC stage
- chip_enable_i_FB  in  1  high = pc_addr_i_FB/inst_i_FB carry a valid fetch this cycle
- inst_i_FB  in  DW  ROM read data for pc_addr_i_FB, same cycle
- flush_i_FB  in  1  discard all buffered and incoming entries (branch/jump redirect)
- ready_i_FB  in  1  decode accepts head entry this cycle
- pc_o_FB  out  AW  PC of head entry
- inst_o_FB  out  DW  instruction of head entry
- valid_o_FB  out  1  head entry valid
- pc_hold_o_FB  out  1  request PC to stop advancing
- count_o_FB  out  log2(DEPTH)+1  occupied entries
- overflow_o_FB  out  1  sticky: a valid fetch was dropped because the buffer was full

## Operation
- Storage: circular array of DEPTH entries {pc, inst}; write pointer wp and read pointer rp, each log2(DEPTH) bits and wrapping modulo DEPTH; count register 0..DEPTH.
- push = chip_enable_i_FB & ~flush_i_FB & (count < DEPTH | pop).
- pop = valid_o_FB & ready_i_FB & ~flush_i_FB.
- On push: write {pc_addr_i_FB, inst_i_FB} at wp, then wp <= wp+1.
- On pop: rp <= rp+1.
- count <= count + push - pop. Push and pop in the same cycle leave count unchanged.
- Full with pop in the same cycle: the push is accepted, since the freed slot is reused.
- Full without pop and chip_enable_i_FB high: the entry is dropped, count stays DEPTH, and overflow_o_FB <= 1.
- Empty: no bypass. An entry written in cycle N is first visible at the outputs in cycle N+1.
- valid_o_FB = (count != 0). pc_o_FB and inst_o_FB = entry[rp]. When valid_o_FB = 0 these outputs are don't-care, but stable.
- pc_hold_o_FB = (count >= DEPTH-SKID), decoded from the registered count with no input paths. The SKID free slots cover fetches already issued while the PC reacts.
- Flush: wp <= 0, rp <= 0, count <= 0. The incoming fetch and any pop in that cycle are both discarded, and ready_i_FB is ignored. overflow_o_FB is not cleared by flush.
- Reset overrides flush and all other inputs.

## Timing
- Reset values: count_o_FB = 0, valid_o_FB = 0, pc_hold_o_FB = 0, overflow_o_FB = 0, pc_o_FB = 0, inst_o_FB = 0. Storage is also cleared to 0.
- Latency from fetch to decode-visible: 1 cycle.
- Throughput: one push and one pop per cycle, sustained.
- pc_hold_o_FB asserts the cycle after count reaches DEPTH-SKID. It deasserts the cycle after count drops below DEPTH-SKID.
- Handshake:
  - The head entry and valid_o_FB stay stable until popped or flushed.
  - ready_i_FB may toggle freely.
  - A pop happens exactly on a rising edge where valid_o_FB & ready_i_FB & ~flush_i_FB.
- Reset mid-operation: buffered entries are lost and outputs return to reset values on the next edge.
- Flush mid-operation: valid_o_FB = 0 in the cycle after flush, regardless of chip_enable_i_FB in the flush cycle.

## Test plan
- Streaming:
  - Stimulus: reset, then ce=1 with PC 0,1,2,… and inst = 0x1000_0000+PC; ready=1.
  - Required: valid_o_FB high from cycle 2; pc_o_FB follows 0,1,2,… with a 1-cycle lag; count stays 1; hold never asserts.
- Stall fill (DEPTH=4, SKID=2, ready=0):
  - Required: count 1,2,3,4; hold asserts after count=2.
  - Fifth fetch (PC 4) is dropped; overflow_o_FB = 1; head stays PC 0.
- Release after stall:
  - Stimulus: from the full state, ce=0, ready=1.
  - Required: PCs 0,1,2,3 appear on consecutive cycles; count 3,2,1,0; hold drops once count < 2.
- Full with simultaneous push and pop:
  - Stimulus: count=4, ready=1, ce=1 with PC 9.
  - Required: count stays 4; PC 9 is later delivered after the existing three entries; no overflow.
- Flush:
  - Stimulus: count=3 with PCs 5,6,7; assert flush with ce=1, PC 8, ready=1.
  - Required: next cycle count=0, valid=0, and PCs 5 and 8 are never delivered.
  - Then PC 0x20 pushed → delivered 1 cycle later.
- Wrap-around and reset:
  - Stimulus: push/pop 10 entries with random ready, so pointers wrap at least twice.
  - Required: in-order delivery, no loss or duplication.
  - Then reset mid-stream → all outputs 0 the next cycle; overflow_o_FB cleared.
